// File: rtl/eth_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// eth_rst_seq_ctrl
//
// Sequences the resets of an Ethernet PHY / MAC / user-logic stack:
//   PHY_RST   : hold the PHY in hard reset        (phy/mac/usr = 1/1/1)
//   PHY_WAIT  : let the PHY settle                 (0/1/1)
//   LINK_WAIT : MAC running, wait for link up      (0/0/1), timeout -> PHY_RST
//   RUN       : everything released                (0/0/0), link loss -> LINK_WAIT
//
// Ports
//   i_clk        clock, all logic on its rising edge
//   i_rst        asynchronous active-high reset
//   i_link_up    PHY link status (asynchronous, synchronised internally)
//   i_soft_rst   one-cycle synchronous request to restart from PHY_RST
//   o_phy_rst    PHY hard reset, active-high (registered)
//   o_mac_rst    MAC reset, active-high (registered)
//   o_usr_rst    user-logic reset, active-high (registered)
//   o_busy       high whenever the state is not RUN (registered)
//   o_timeout    one-cycle pulse on a LINK_WAIT timeout
//   o_retry_cnt  number of link timeouts since i_rst, saturating at 255
//   o_state      current state: 0 PHY_RST, 1 PHY_WAIT, 2 LINK_WAIT, 3 RUN
// ---------------------------------------------------------------------------
module eth_rst_seq_ctrl #(
  parameter int P_PHY_RST_CYCLE  = 10,
  parameter int P_PHY_WAIT_CYCLE = 20,
  parameter int P_LINK_TIMEOUT   = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_link_up,
  input  logic       i_soft_rst,
  output logic       o_phy_rst,
  output logic       o_mac_rst,
  output logic       o_usr_rst,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [7:0] o_retry_cnt,
  output logic [1:0] o_state
);

  // A length of 0 would never match the counter; run such states for 1 cycle.
  localparam int PHY_RST_EFF   = (P_PHY_RST_CYCLE  < 1) ? 1 : P_PHY_RST_CYCLE;
  localparam int PHY_WAIT_EFF  = (P_PHY_WAIT_CYCLE < 1) ? 1 : P_PHY_WAIT_CYCLE;
  localparam int LINK_TO_EFF   = (P_LINK_TIMEOUT   < 1) ? 1 : P_LINK_TIMEOUT;

  // A state of length N exits on the edge where the counter reads N-1.
  localparam logic [23:0] PHY_RST_LAST  = 24'(PHY_RST_EFF  - 1);
  localparam logic [23:0] PHY_WAIT_LAST = 24'(PHY_WAIT_EFF - 1);
  localparam logic [23:0] LINK_TO_LAST  = 24'(LINK_TO_EFF  - 1);

  typedef enum logic [1:0] {
    ST_PHY_RST   = 2'd0,
    ST_PHY_WAIT  = 2'd1,
    ST_LINK_WAIT = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic        link_meta_p0;
  logic        link_sync_p1;
  state_t      state;
  state_t      state_nxt;
  logic [23:0] cnt;
  logic [23:0] cnt_nxt;
  logic        timeout_nxt;

  // ---- stage p0/p1: two-flop synchroniser for the asynchronous link status
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      link_meta_p0 <= 1'b0;
      link_sync_p1 <= 1'b0;
    end else begin
      link_meta_p0 <= i_link_up;
      link_sync_p1 <= link_meta_p0;
    end
  end

  // ---- next-state logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 24'd1;
    timeout_nxt = 1'b0;
    if (i_soft_rst) begin
      // Soft restart wins over any timeout or link event on the same edge.
      state_nxt = ST_PHY_RST;
      cnt_nxt   = 24'd0;
    end else begin
      case (state)
        ST_PHY_RST: begin
          if (cnt == PHY_RST_LAST) begin
            state_nxt = ST_PHY_WAIT;
            cnt_nxt   = 24'd0;
          end
        end
        ST_PHY_WAIT: begin
          if (cnt == PHY_WAIT_LAST) begin
            state_nxt = ST_LINK_WAIT;
            cnt_nxt   = 24'd0;
          end
        end
        ST_LINK_WAIT: begin
          // A link arriving on the timeout edge is honoured rather than retried.
          if (link_sync_p1) begin
            state_nxt = ST_RUN;
            cnt_nxt   = 24'd0;
          end else if (cnt == LINK_TO_LAST) begin
            state_nxt   = ST_PHY_RST;
            cnt_nxt     = 24'd0;
            timeout_nxt = 1'b1;
          end
        end
        ST_RUN: begin
          // RUN is untimed; the counter idles at 0 so LINK_WAIT starts clean.
          cnt_nxt = 24'd0;
          if (!link_sync_p1) begin
            state_nxt = ST_LINK_WAIT;
          end
        end
        default: begin
          state_nxt = ST_PHY_RST;
          cnt_nxt   = 24'd0;
        end
      endcase
    end
  end

  // ---- state register and registered outputs
  // Outputs are decoded from state_nxt and registered alongside the state, so
  // they change on the same edge as the state and are free of glitches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_PHY_RST;
      cnt         <= 24'd0;
      o_phy_rst   <= 1'b1;
      o_mac_rst   <= 1'b1;
      o_usr_rst   <= 1'b1;
      o_busy      <= 1'b1;
      o_timeout   <= 1'b0;
      o_retry_cnt <= 8'd0;
      o_state     <= 2'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_phy_rst   <= (state_nxt == ST_PHY_RST);
      o_mac_rst   <= (state_nxt == ST_PHY_RST) || (state_nxt == ST_PHY_WAIT);
      o_usr_rst   <= (state_nxt != ST_RUN);
      o_busy      <= (state_nxt != ST_RUN);
      o_timeout   <= timeout_nxt;
      o_state     <= state_nxt;
      if (timeout_nxt) begin
        o_retry_cnt <= sat_inc8(o_retry_cnt);
      end
    end
  end

endmodule

// File: tb/tb_eth_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eth_rst_seq_ctrl
//
// Scoreboard bench for eth_rst_seq_ctrl with default timing parameters
// (PHY reset 10, PHY settle 20, link timeout 50). Expected output values are
// queued per clock edge (edge 1 = first rising edge after reset release) and
// compared at the following falling edge.
// ---------------------------------------------------------------------------
module tb_eth_rst_seq_ctrl;

  logic       i_clk;
  logic       i_rst;
  logic       i_link_up;
  logic       i_soft_rst;
  logic       o_phy_rst;
  logic       o_mac_rst;
  logic       o_usr_rst;
  logic       o_busy;
  logic       o_timeout;
  logic [7:0] o_retry_cnt;
  logic [1:0] o_state;

  eth_rst_seq_ctrl #(
    .P_PHY_RST_CYCLE  (10),
    .P_PHY_WAIT_CYCLE (20),
    .P_LINK_TIMEOUT   (50)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_link_up   (i_link_up),
    .i_soft_rst  (i_soft_rst),
    .o_phy_rst   (o_phy_rst),
    .o_mac_rst   (o_mac_rst),
    .o_usr_rst   (o_usr_rst),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout),
    .o_retry_cnt (o_retry_cnt),
    .o_state     (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam int F_PHY   = 0;
  localparam int F_MAC   = 1;
  localparam int F_USR   = 2;
  localparam int F_BUSY  = 3;
  localparam int F_TO    = 4;
  localparam int F_RETRY = 5;
  localparam int F_STATE = 6;

  typedef struct {
    int edge_n;
    int fld;
    int val;
  } exp_t;

  exp_t q[$];
  int   edge_n;
  int   n_checks;
  int   n_errors;
  string scen;

  function automatic string fld_name(input int f);
    case (f)
      F_PHY:   return "phy_rst";
      F_MAC:   return "mac_rst";
      F_USR:   return "usr_rst";
      F_BUSY:  return "busy";
      F_TO:    return "timeout";
      F_RETRY: return "retry_cnt";
      default: return "state";
    endcase
  endfunction

  function automatic int obs_of(input int f);
    case (f)
      F_PHY:   return int'(o_phy_rst);
      F_MAC:   return int'(o_mac_rst);
      F_USR:   return int'(o_usr_rst);
      F_BUSY:  return int'(o_busy);
      F_TO:    return int'(o_timeout);
      F_RETRY: return int'(o_retry_cnt);
      default: return int'(o_state);
    endcase
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp_at(input int e, input int f, input int v);
    exp_t x;
    x.edge_n = e;
    x.fld    = f;
    x.val    = v;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (q.size() != 0 && q[0].edge_n <= edge_n) begin
      x = q.pop_front();
      check_eq($sformatf("%s/%s@%0d", scen, fld_name(x.fld), x.edge_n),
               obs_of(x.fld), x.val);
    end
  endtask

  // Advance one rising edge and compare everything expected for it.
  task automatic tick();
    @(posedge i_clk);
    edge_n++;
    @(negedge i_clk);
    drain();
  endtask

  // Run until edge `last`; i_soft_rst is high for the edge numbered soft_edge.
  task automatic run_to(input int last, input int soft_edge);
    while (edge_n < last) begin
      i_soft_rst = (edge_n + 1 == soft_edge);
      tick();
    end
    i_soft_rst = 1'b0;
  endtask

  task automatic flush_unconsumed();
    exp_t x;
    while (q.size() != 0) begin
      x = q.pop_front();
      check_eq($sformatf("%s/unreached_%s@%0d", scen, fld_name(x.fld), x.edge_n),
               -1, x.val);
    end
  endtask

  // Assert reset between clock edges, check the outputs respond without an
  // edge, then release so that the next rising edge is edge 1.
  task automatic do_reset(input logic link);
    @(negedge i_clk);
    i_link_up  = link;
    i_soft_rst = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    check_eq({scen, "/rst_phy"},   int'(o_phy_rst),   1);
    check_eq({scen, "/rst_mac"},   int'(o_mac_rst),   1);
    check_eq({scen, "/rst_usr"},   int'(o_usr_rst),   1);
    check_eq({scen, "/rst_busy"},  int'(o_busy),      1);
    check_eq({scen, "/rst_to"},    int'(o_timeout),   0);
    check_eq({scen, "/rst_retry"}, int'(o_retry_cnt), 0);
    check_eq({scen, "/rst_state"}, int'(o_state),     0);
    @(negedge i_clk);
    i_rst  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    edge_n     = 0;
    i_rst      = 1'b1;
    i_link_up  = 1'b0;
    i_soft_rst = 1'b0;

    // Link already up: straight through to RUN.
    scen = "seq";
    do_reset(1'b1);
    exp_at(9,  F_PHY, 1);   exp_at(9,  F_STATE, 0);
    exp_at(10, F_PHY, 0);   exp_at(10, F_MAC, 1);   exp_at(10, F_STATE, 1);
    exp_at(29, F_MAC, 1);   exp_at(29, F_STATE, 1);
    exp_at(30, F_MAC, 0);   exp_at(30, F_USR, 1);   exp_at(30, F_BUSY, 1);
    exp_at(30, F_STATE, 2);
    exp_at(31, F_USR, 0);   exp_at(31, F_BUSY, 0);  exp_at(31, F_STATE, 3);
    exp_at(31, F_TO, 0);    exp_at(31, F_PHY, 0);
    run_to(31, 0);
    flush_unconsumed();

    // Link drops before edge 34 and returns before edge 40.
    scen = "linkloss";
    exp_at(35, F_STATE, 3); exp_at(35, F_USR, 0);
    exp_at(36, F_STATE, 2); exp_at(36, F_USR, 1);   exp_at(36, F_MAC, 0);
    exp_at(36, F_PHY, 0);   exp_at(36, F_BUSY, 1);
    exp_at(41, F_STATE, 2); exp_at(41, F_USR, 1);
    exp_at(42, F_STATE, 3); exp_at(42, F_USR, 0);   exp_at(42, F_BUSY, 0);
    while (edge_n < 44) begin
      i_link_up = !((edge_n + 1 >= 34) && (edge_n + 1 < 40));
      tick();
    end
    flush_unconsumed();

    // Asynchronous reset in the middle of RUN.
    scen = "asyncrst";
    check_eq("asyncrst/state_before", int'(o_state), 3);
    do_reset(1'b0);

    // Link never comes up: repeated timeouts until the retry count saturates.
    scen = "timeout";
    exp_at(30, F_STATE, 2);
    exp_at(79, F_STATE, 2); exp_at(79, F_TO, 0);    exp_at(79, F_RETRY, 0);
    for (int n = 1; n <= 257; n++) begin
      exp_at(80 * n, F_TO, 1);
      exp_at(80 * n, F_RETRY, (n > 255) ? 255 : n);
      if (n == 1) begin
        exp_at(80, F_STATE, 0); exp_at(80, F_PHY, 1); exp_at(80, F_MAC, 1);
      end
      exp_at(80 * n + 1, F_TO, 0);
    end
    run_to(80 * 257 + 1, 0);
    flush_unconsumed();

    // Soft restart while PHY_WAIT counter reads 5.
    scen = "softrst";
    do_reset(1'b1);
    exp_at(15, F_STATE, 1); exp_at(15, F_PHY, 0);
    exp_at(16, F_STATE, 0); exp_at(16, F_PHY, 1);   exp_at(16, F_MAC, 1);
    exp_at(25, F_PHY, 1);   exp_at(25, F_STATE, 0);
    exp_at(26, F_PHY, 0);   exp_at(26, F_STATE, 1);
    exp_at(45, F_MAC, 1);
    exp_at(46, F_MAC, 0);   exp_at(46, F_STATE, 2); exp_at(46, F_USR, 1);
    exp_at(47, F_USR, 0);   exp_at(47, F_STATE, 3); exp_at(47, F_BUSY, 0);
    run_to(48, 16);
    flush_unconsumed();

    // Soft restart on the exact timeout edge suppresses the timeout.
    scen = "softvsto";
    do_reset(1'b0);
    exp_at(79, F_STATE, 2);
    exp_at(80, F_TO, 0);    exp_at(80, F_RETRY, 0); exp_at(80, F_STATE, 0);
    exp_at(80, F_PHY, 1);
    exp_at(81, F_TO, 0);    exp_at(81, F_RETRY, 0);
    exp_at(159, F_STATE, 2); exp_at(159, F_RETRY, 0);
    exp_at(160, F_TO, 1);   exp_at(160, F_RETRY, 1); exp_at(160, F_STATE, 0);
    run_to(161, 80);
    flush_unconsumed();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_rst_seq_ctrl.md
ETH_RST_SEQ_CTRL -- requirements
Module: eth_rst_seq_ctrl

Interface
REQ-001 P_PHY_RST_CYCLE, 10, cycles the PHY hard reset is held; 0 is treated as 1.
REQ-002 P_PHY_WAIT_CYCLE, 20, PHY settle cycles before MAC release; 0 is treated as 1.
REQ-003 P_LINK_TIMEOUT, 50, max cycles in LINK_WAIT before retry; 0 is treated as 1.
REQ-004 i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_link_up  input  1  PHY link status, asynchronous to i_clk.
REQ-007 i_soft_rst  input  1  synchronous one-cycle request to restart the sequence.
REQ-008 o_phy_rst  output  1  PHY hard reset, active-high.
REQ-009 o_mac_rst  output  1  MAC reset, active-high.
REQ-010 o_usr_rst  output  1  user-logic reset, active-high.
REQ-011 o_busy  output  1  high whenever state is not RUN.
REQ-012 o_timeout  output  1  one-cycle pulse on link-wait timeout.
REQ-013 o_retry_cnt  output  8  count of timeouts since i_rst.
REQ-014 o_state  output  2  current state: 0 PHY_RST, 1 PHY_WAIT, 2 LINK_WAIT, 3 RUN.

Function
REQ-015 The block SHALL implement a 4-state FSM PHY_RST -> PHY_WAIT -> LINK_WAIT -> RUN, with a 24-bit cycle counter cleared on every state entry.
REQ-016 The counter SHALL increment each cycle in a timed state; a state of length N SHALL exit on the edge where the counter equals N-1, so the state lasts exactly N cycles.
REQ-017 PHY_RST SHALL drive phy/mac/usr resets = 1/1/1 and exit to PHY_WAIT after P_PHY_RST_CYCLE cycles.
REQ-018 PHY_WAIT SHALL drive 0/1/1 and exit to LINK_WAIT after P_PHY_WAIT_CYCLE cycles.
REQ-019 LINK_WAIT SHALL drive 0/0/1, exit to RUN on the first edge where the synchronised link is 1, and otherwise exit to PHY_RST on the edge where the counter equals P_LINK_TIMEOUT-1.
REQ-020 On a LINK_WAIT timeout the block SHALL pulse o_timeout for one cycle and increment o_retry_cnt, saturating at 255.
REQ-021 RUN SHALL drive 0/0/0 and return to LINK_WAIT (counter cleared, o_usr_rst reasserted, o_mac_rst kept 0) on the edge where the synchronised link is 0.
REQ-022 i_link_up SHALL pass through a 2-flop synchroniser, giving 2 cycles of latency before it is used by the FSM.
REQ-023 i_soft_rst=1 in any state SHALL force PHY_RST on the next edge, with the counter cleared.
REQ-024 i_soft_rst SHALL take priority over a timeout or link event on the same edge; in that case o_timeout stays 0 and o_retry_cnt is not incremented.
REQ-025 o_phy_rst, o_mac_rst, o_usr_rst, o_busy and o_state SHALL be registered and SHALL update on the same edge as the state register, with no combinational path from any input.
REQ-026 o_retry_cnt SHALL be cleared only by i_rst.
REQ-027 Reset outputs SHALL never glitch; each SHALL change at most once per edge.

Reset
REQ-028 i_rst=1 SHALL immediately, without a clock edge, set state to PHY_RST, counter 0, synchroniser flops 0, o_phy_rst/o_mac_rst/o_usr_rst=1, o_busy=1, o_timeout=0, o_retry_cnt=0, o_state=0.
REQ-029 After i_rst falls, the sequence SHALL start from PHY_RST with counter 0; edge 1 is the first rising edge after release.

Verification (defaults P_PHY_RST_CYCLE=10, P_PHY_WAIT_CYCLE=20, P_LINK_TIMEOUT=50)
REQ-030 i_link_up=1 held, release i_rst -> o_phy_rst falls at edge 10, o_mac_rst at edge 30, o_usr_rst and o_busy at edge 31, o_state=3.
REQ-031 i_link_up=0 held -> o_timeout pulses at edge 80, state returns to 0, o_phy_rst=o_mac_rst=1, o_retry_cnt=1; after 256 timeouts o_retry_cnt stays 255.
REQ-032 In RUN, drop i_link_up before edge k -> o_usr_rst=1 and o_state=2 at edge k+2, o_mac_rst stays 0; link restored -> o_usr_rst=0 two to three edges later.
REQ-033 i_soft_rst pulse at PHY_WAIT counter=5 -> next edge o_state=0 and o_phy_rst=1, then full 10/20 timing repeats.
REQ-034 i_soft_rst coincident with the timeout edge -> o_timeout stays 0, o_retry_cnt unchanged, o_state=0.
REQ-035 i_rst asserted mid-RUN between clock edges -> all reset outputs 1 and o_state=0 before the next edge.
